// File: rtl/po2_pkg.sv
// ---------------------------------------------------------------------------
// po2_pkg : shared types, Q-format constants and width helpers for the
//           power-of-two datapath.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package po2_pkg;

  localparam int PO2_W      = 16;
  localparam int PO2_I      = 4;
  localparam int PO2_PROD_W = 2 * PO2_W;
  localparam int PO2_PROD_I = 2 * PO2_I;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    BIAS   = 2'd1,
    CLIP   = 2'd2,
    OUTPUT = 2'd3
  } po2_state_e;

  function automatic int frac_bits(input int w, input int i);
    return w - i;
  endfunction

  function automatic int acc_width(input int w, input int k);
    return 2 * w + $clog2(k) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/po2_narrow.sv
// ---------------------------------------------------------------------------
// po2_narrow : combinational arithmetic right shift of a wide signed value
//              followed by saturation to a W-bit signed result.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module po2_narrow
  import po2_pkg::*;
#(
  parameter int AW    = acc_width(PO2_W, 4),
  parameter int W     = PO2_W,
  parameter int SHIFT = frac_bits(PO2_W, PO2_I)
) (
  input  logic signed [AW-1:0] din,
  output logic signed [W-1:0]  data,
  output logic                 sat
);

  logic signed [AW-1:0] shifted;
  logic [AW-W:0]        hi;

  // The value fits in W bits only when every bit above the result's sign bit
  // replicates that sign bit.
  always_comb begin
    shifted = din >>> SHIFT;
    hi      = shifted[AW-1:W-1];
    data    = shifted[W-1:0];
    sat     = 1'b0;
    if (!(&hi) && (|hi)) begin
      sat  = 1'b1;
      data = shifted[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/po2_accumulate.sv
// ---------------------------------------------------------------------------
// po2_accumulate : sums K double-width products, adds a per-frame bias,
//                  optionally rounds (PO2_ACC_ROUND_EN), saturates to Q(I).(W-I).
//                  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module po2_accumulate
  import po2_pkg::*;
#(
  parameter int W  = 16,
  parameter int I  = 4,
  parameter int K  = 4,
  parameter int AW = acc_width(W, K)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [2*W-1:0] in_data,
  input  logic                  in_v,
  output logic                  in_ready,
  input  logic signed [W-1:0]   bias,
  output logic signed [W-1:0]   out_data,
  output logic                  out_v,
  input  logic                  out_ready,
  output logic                  out_sat
);

  localparam int FRAC = frac_bits(W, I);
  localparam int CW   = $clog2(K + 1);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  po2_state_e           state;
  logic signed [AW-1:0] acc;
  logic [CW-1:0]        cnt;
  logic signed [W-1:0]  bias_q;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] bias_ext;
  logic signed [AW-1:0] rnd;
  logic signed [W-1:0]  nar_data;
  logic                 nar_sat;
  logic                 accept;

  assign in_ready = (state == ACCUM) && !rst;
  assign accept   = in_v && in_ready;

  assign prod_ext = {{(AW-2*W){in_data[2*W-1]}}, in_data};
  // Bias is moved into the product's fractional alignment before extension.
  assign bias_ext = {{(AW-2*W+I){bias_q[W-1]}}, bias_q, {FRAC{1'b0}}};

`ifdef PO2_ACC_ROUND_EN
  assign rnd = AW'(1) << (FRAC - 1);
`else
  assign rnd = '0;
`endif

  po2_narrow #(
    .AW    (AW),
    .W     (W),
    .SHIFT (FRAC)
  ) u_narrow (
    .din  (acc),
    .data (nar_data),
    .sat  (nar_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      bias_q   <= '0;
      out_v    <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc <= acc + prod_ext;
            cnt <= cnt + 1'b1;
            if (cnt == '0) bias_q <= bias;
            if (cnt == LAST) state <= BIAS;
          end
        end
        BIAS: begin
          acc   <= acc + bias_ext + rnd;
          state <= CLIP;
        end
        CLIP: begin
          out_data <= nar_data;
          out_sat  <= nar_sat;
          out_v    <= 1'b1;
          state    <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_v <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_po2_accumulate.sv
// ---------------------------------------------------------------------------
// tb_po2_accumulate : self-checking bench for po2_accumulate (W=16,I=4,K=4).
//                     Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_po2_accumulate;

  localparam int K = 4;

  logic               clk;
  logic               rst;
  logic signed [31:0] in_data;
  logic               in_v;
  logic               in_ready;
  logic signed [15:0] bias;
  logic signed [15:0] out_data;
  logic               out_v;
  logic               out_ready;
  logic               out_sat;

  int errors;
  int checks;
  int lat;

  logic [31:0] prods  [K];
  logic [15:0] biases [K];

  po2_accumulate #(.W(16), .I(4), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_v      (in_v),
    .in_ready  (in_ready),
    .bias      (bias),
    .out_data  (out_data),
    .out_v     (out_v),
    .out_ready (out_ready),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact sum in Q.24, bias scaled into Q.24, optional half-LSB,
  // floor division by 2^12, then clamp to the 16-bit signed range.
  function automatic void model(output logic [15:0] d, output logic s);
    longint sum;
    longint q;
    sum = 0;
    for (int k = 0; k < K; k++) sum += longint'($signed(prods[k]));
    sum += longint'($signed(biases[0])) * 4096;
`ifdef PO2_ACC_ROUND_EN
    sum += 2048;
`endif
    q = sum / 4096;
    if ((sum % 4096 != 0) && (sum < 0)) q = q - 1;
    s = 1'b0;
    if (q > 32767) begin
      q = 32767; s = 1'b1;
    end else if (q < -32768) begin
      q = -32768; s = 1'b1;
    end
    d = q[15:0];
  endfunction

  function automatic void set_frame(input logic [31:0] p, input logic [15:0] b);
    for (int k = 0; k < K; k++) begin
      prods[k]  = p;
      biases[k] = b;
    end
  endfunction

  // Presents prods[] with optional random stalls; lat is edges from the K-th
  // accept to observing out_v, or -1 if the frame could not be delivered.
  task automatic send_frame(input int gap_max);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < K && guard < 200) begin
      guard++;
      if (gap_max > 0 && $urandom_range(0, gap_max) == 0) begin
        in_v = 1'b0;
        @(posedge clk); #1;
      end else begin
        in_v    = 1'b1;
        in_data = prods[sent];
        bias    = biases[sent];
        if (in_ready) begin
          @(posedge clk); #1;
          sent++;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    in_v = 1'b0;
    if (sent < K) begin
      lat = -1;
    end else begin
      lat = 0;
      while (!out_v && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  task automatic handshake(input int delay);
    for (int i = 0; i < delay; i++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v got=%b want=0", out_v); end
    checks++;
    if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data got=%h want=0000", out_data); end
    checks++;
    if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got=%b want=0", out_sat); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_basic;
    set_frame(32'h0080_0000, 16'h0000);
    send_frame(0);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL basic_latency got=%0d want=2", lat); end
    checks++;
    if (out_data !== 16'h2000) begin errors++; $display("FAIL basic_data got=%h want=2000", out_data); end
    checks++;
    if (out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got=%b want=0", out_sat); end
    handshake(0);
    checks++;
    if (out_v !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release got out_v=%b in_ready=%b want 0/1", out_v, in_ready);
    end
  endtask

  task automatic test_saturate;
    set_frame(32'h0700_0000, 16'h1000);
    send_frame(0);
    checks++;
    if (lat != 2 || out_data !== 16'h7FFF || out_sat !== 1'b1) begin
      errors++; $display("FAIL sat_pos got=%h sat=%b lat=%0d want=7fff sat=1 lat=2", out_data, out_sat, lat);
    end
    handshake(1);
    set_frame(32'hF900_0000, 16'h0000);
    send_frame(0);
    checks++;
    if (lat != 2 || out_data !== 16'h8000 || out_sat !== 1'b1) begin
      errors++; $display("FAIL sat_neg got=%h sat=%b lat=%0d want=8000 sat=1 lat=2", out_data, out_sat, lat);
    end
    handshake(0);
  endtask

  task automatic test_rounding;
    logic [15:0] exp_pos;
    logic [15:0] exp_neg;
`ifdef PO2_ACC_ROUND_EN
    exp_pos = 16'h0001;
    exp_neg = 16'h0000;
`else
    exp_pos = 16'h0000;
    exp_neg = 16'hFFFF;
`endif
    set_frame(32'h0000_0000, 16'h0000);
    prods[0] = 32'h0000_0800;
    send_frame(0);
    checks++;
    if (lat != 2 || out_data !== exp_pos || out_sat !== 1'b0) begin
      errors++; $display("FAIL round_pos got=%h sat=%b lat=%0d want=%h", out_data, out_sat, lat, exp_pos);
    end
    handshake(0);
    prods[0] = 32'hFFFF_F800;
    send_frame(0);
    checks++;
    if (lat != 2 || out_data !== exp_neg || out_sat !== 1'b0) begin
      errors++; $display("FAIL round_neg got=%h sat=%b lat=%0d want=%h", out_data, out_sat, lat, exp_neg);
    end
    handshake(0);
  endtask

  task automatic test_backpressure;
    logic [15:0] held;
    logic        held_sat;
    set_frame(32'h0100_0000, 16'h0800);
    send_frame(0);
    held     = out_data;
    held_sat = out_sat;
    checks++;
    if (lat != 2 || held !== 16'h4800) begin
      errors++; $display("FAIL bp_first got=%h lat=%0d want=4800 lat=2", held, lat);
    end
    out_ready = 1'b0;
    in_v      = 1'b1;
    in_data   = 32'sh0040_0000;
    bias      = 16'sh0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_v !== 1'b1 || out_data !== held || out_sat !== held_sat || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got out_v=%b data=%h sat=%b in_ready=%b want 1/%h/%b/0",
                 i, out_v, out_data, out_sat, in_ready, held, held_sat);
      end
    end
    handshake(0);
    checks++;
    if (out_v !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got out_v=%b in_ready=%b want 0/1", out_v, in_ready);
    end
    set_frame(32'h0040_0000, 16'h0000);
    send_frame(0);
    checks++;
    if (lat != 2 || out_data !== 16'h1000 || out_sat !== 1'b0) begin
      errors++; $display("FAIL bp_next got=%h sat=%b lat=%0d want=1000", out_data, out_sat, lat);
    end
    handshake(0);
  endtask

  task automatic test_bias_sample;
    set_frame(32'h0000_0000, 16'h2000);
    biases[0] = 16'h1000;
    send_frame(0);
    checks++;
    if (lat != 2 || out_data !== 16'h1000 || out_sat !== 1'b0) begin
      errors++; $display("FAIL bias_sample got=%h sat=%b lat=%0d want=1000", out_data, out_sat, lat);
    end
    handshake(0);
  endtask

  task automatic test_async_reset;
    in_v    = 1'b1;
    in_data = 32'sh0100_0000;
    bias    = 16'sh0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_v = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_v !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outputs got out_v=%b data=%h sat=%b in_ready=%b want all 0",
               out_v, out_data, out_sat, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    set_frame(32'h0040_0000, 16'h0000);
    send_frame(0);
    checks++;
    if (lat != 2 || out_data !== 16'h1000 || out_sat !== 1'b0) begin
      errors++; $display("FAIL async_reset_frame got=%h sat=%b lat=%0d want=1000", out_data, out_sat, lat);
    end
    handshake(0);
  endtask

  task automatic test_random;
    logic [15:0] exp_d;
    logic        exp_s;
    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < K; k++) begin
        case ($urandom_range(0, 2))
          0:       prods[k] = $urandom;
          1:       prods[k] = 32'($urandom_range(0, 32'h01FF_FFFF)) - 32'h0100_0000;
          default: prods[k] = 32'($urandom_range(0, 8191)) - 32'd4096;
        endcase
        biases[k] = 16'($urandom);
      end
      model(exp_d, exp_s);
      out_ready = 1'($urandom_range(0, 1));
      send_frame(3);
      checks++;
      if (lat != 2 || out_data !== exp_d || out_sat !== exp_s) begin
        errors++;
        $display("FAIL random frame=%0d got=%h sat=%b lat=%0d want=%h sat=%b lat=2",
                 f, out_data, out_sat, lat, exp_d, exp_s);
      end
      handshake(int'($urandom_range(0, 3)));
      checks++;
      if (out_v !== 1'b0) begin errors++; $display("FAIL random_release frame=%0d got=%b want=0", f, out_v); end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    lat       = 0;
    rst       = 1'b1;
    in_v      = 1'b0;
    in_data   = '0;
    bias      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_saturate();
    test_rounding();
    test_backpressure();
    test_bias_sample();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/po2_accumulate.md
# po2_accumulate

Downstream stage of the power-of-two multiplier. It consumes a stream of double-width signed products, one per weight tap, and sums K of them into a guarded accumulator. It then adds a per-frame bias, rounds, and saturates back to the single-width fixed-point format. The result is presented on a valid/ready output as one neuron or tap output of the dilated causal convolution.

## Interface
Parameters:
- W, 16: single-width element width; output format Q(I).(W-I).
- I, 4: integer bits in W; products arrive as Q(2I).(2W-2I).
- K, 4: products summed per frame; legal range is K ≥ 2.
- AW, 2*W+$clog2(K)+1: accumulator width. Derived; do not override.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous active-high reset. One clock; reset is asynchronous and active-high.
- in_data  in  signed [2W-1:0]  product from the multiplier, Q(2I).(2W-2I).
- in_v  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- bias  in  signed [W-1:0]  Q(I).(W-I); sampled on the first accepted product of a frame.
- out_data  out  signed [W-1:0]  rounded, saturated sum, Q(I).(W-I).
- out_v  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_sat  out  1  saturation occurred for the current out_data.

## Operation
- States:
  - ACCUM: in_ready=1. Each cycle with in_v&in_ready, acc <= acc + sign_extend(in_data) and cnt <= cnt+1. On the K-th accept, go to BIAS.
  - BIAS: acc <= acc + ({bias, (W-I) zero LSBs} sign-extended to AW). Under rounding, also add 2^(W-I-1). Go to CLIP.
  - CLIP: form t = acc >>> (W-I), arithmetic shift.
    - If t > 2^(W-1)-1: out_data=16'h7FFF-equivalent, out_sat=1.
    - If t < -2^(W-1): out_data=-2^(W-1), out_sat=1.
    - Otherwise: out_data=t[W-1:0], out_sat=0.
    - out_v <= 1. Go to OUTPUT.
  - OUTPUT: hold out_data and out_sat stable while out_v=1. On out_ready, out_v <= 0, acc <= 0, cnt <= 0, go to ACCUM.
- Bias sampling:
  - Bias is captured into a bias register on the first accept of a frame (cnt==0).
  - Later bias changes do not affect that frame.
- Accumulator width: AW guarantees K full-scale products plus bias cannot overflow. No wrap-around is permitted internally.
- in_ready=0 in BIAS, CLIP and OUTPUT. Products presented then are not consumed, and upstream holds them.
- Reset at any time:
  - Values: state=ACCUM, acc=0, cnt=0, in_ready=1 after deassert, out_v=0, out_data=0, out_sat=0, bias register=0.
  - A partial frame is discarded.

## Timing
- Throughput: one product per cycle in ACCUM.
- Latency: the K-th accept is at edge N. out_v rises at edge N+2 (BIAS at N+1, CLIP registers at N+2).
- Frame period with no backpressure: K+3 cycles, because the OUTPUT handshake takes ≥1 cycle.
- A handshake occurs on the edge where out_v&out_ready. The next product is accepted at the earliest one cycle later.
- out_ready asserted before out_v has no effect.
- in_v low mid-frame stalls cnt. There is no timeout.

## Configuration
- PO2_ACC_ROUND_EN defined: BIAS adds 2^(W-I-1), giving round-half-up (toward +inf) when dropping W-I LSBs.
- PO2_ACC_ROUND_EN undefined: no addend; the result is truncated toward -inf by the arithmetic shift.
- Saturation logic is identical in both builds.

## Structure
- Package po2_pkg holds:
  - the state enum (ACCUM, BIAS, CLIP, OUTPUT);
  - the frac_bits(W,I) and acc_width(W,K) helper functions;
  - the Q-format localparams shared with the multiplier.
- Sub-module po2_narrow: combinational AW-to-W arithmetic shift plus saturate. Outputs are data and sat. It is instantiated once in CLIP and reusable by other narrowing stages.

## Test plan
- W=16,I=4,K=4, bias=0, four products 0x00800000 (0.5): out_data=0x2000, out_sat=0, out_v exactly 2 cycles after the 4th accept.
- Four products 0x07000000 (7.0), bias 0x1000: out_data=0x7FFF, out_sat=1. Four products 0xF9000000 (-7.0), bias 0: out_data=0x8000, out_sat=1.
- Products 0x00000800, 0, 0, 0, bias 0:
  - with PO2_ACC_ROUND_EN, out_data=0x0001;
  - without it, 0x0000.
  - Products 0xFFFFF800,0,0,0 without the macro give 0xFFFF.
- Backpressure: out_ready low for 5 cycles after out_v. out_data/out_sat stay stable, in_ready=0, and products held by upstream are not consumed. The next frame starts after the handshake.
- Bias changes from 0x1000 to 0x2000 after the first accept, products all 0: out_data=0x1000.
- Reset pulse asynchronously after 2 of 4 products (0x01000000 each). The next 4 products of 0x00400000 give out_data=0x1000, with all outputs 0 during reset.
